// File: rtl/alu_issue_ctrl.sv
`timescale 1ns / 1ps
// -----------------------------------------------------------------------------
// alu_issue_ctrl
//
// Issue/capture controller sitting directly upstream of the EX-stage ALU/divider.
// Accepts one operation at a time from ID (valid/ready) and registers the operator
// and operands that drive the ALU. It keeps the ALU enabled until the result is
// available: one cycle for ordinary ops, or until alu_ready_i for the divide class.
// The result is captured into an output register that feeds writeback over a
// second valid/ready handshake.
//
// Optional feature macro: ALU_ISSUE_TIMEOUT_EN
//   When this macro is defined, a watchdog aborts a divide after TIMEOUT_CYCLES
//   EXEC cycles. The aborted op returns result 32'hFFFF_FFFF with wb_err_o = 1.
//   When the macro is undefined, a divide waits indefinitely and wb_err_o is
//   always 0.
//
// Ports:
//   core_clk, rst                 clock, asynchronous active-high reset
//   id_valid_i / id_ready_o       ID handshake
//   id_operator_i, id_operand_*_i operation from ID
//   alu_enable_o, alu_operator_o,
//   alu_operand_*_o, alu_ex_ready_o   registered drive into the ALU
//   alu_result_i, alu_comparison_result_i, alu_ready_i   ALU responses
//   wb_valid_o / wb_ready_i       writeback handshake
//   wb_result_o, wb_cmp_o, wb_err_o   captured result, comparison flag, abort flag
//   busy_o                        controller not idle
// -----------------------------------------------------------------------------
module alu_issue_ctrl #(
  parameter int unsigned OPCODE_W       = 7,
  parameter int unsigned TIMEOUT_CYCLES = 64
) (
  input  logic                core_clk,
  input  logic                rst,
  input  logic                id_valid_i,
  output logic                id_ready_o,
  input  logic [OPCODE_W-1:0] id_operator_i,
  input  logic [31:0]         id_operand_a_i,
  input  logic [31:0]         id_operand_b_i,
  output logic                alu_enable_o,
  output logic [OPCODE_W-1:0] alu_operator_o,
  output logic [31:0]         alu_operand_a_o,
  output logic [31:0]         alu_operand_b_o,
  output logic                alu_ex_ready_o,
  input  logic [31:0]         alu_result_i,
  input  logic                alu_comparison_result_i,
  input  logic                alu_ready_i,
  output logic                wb_valid_o,
  input  logic                wb_ready_i,
  output logic [31:0]         wb_result_o,
  output logic                wb_cmp_o,
  output logic                wb_err_o,
  output logic                busy_o
);

  typedef enum logic [1:0] {IDLE, EXEC, HOLD} state_e;

  state_e              state_q, state_d;
  logic [OPCODE_W-1:0] op_q, op_d;
  logic [31:0]         a_q, a_d, b_q, b_d, res_q, res_d;
  logic                cmp_q, cmp_d, err_q, err_d;
  logic                en_q, en_d, wbv_q, wbv_d, busy_q, busy_d;
  logic                accept, is_div, timeout;

  // HOLD can accept a new op in the same edge that retires the old result.
  assign id_ready_o = (state_q == IDLE) || ((state_q == HOLD) && wb_ready_i);
  assign accept     = id_valid_i && id_ready_o;
  // DIVU, DIV, REMU and REM share the operator prefix 5'b01100.
  assign is_div     = (op_q[6:2] == 5'b01100);

`ifdef ALU_ISSUE_TIMEOUT_EN
  localparam int unsigned CNT_W = $clog2(TIMEOUT_CYCLES + 1);
  logic [CNT_W-1:0] cnt_q, cnt_d;

  // cnt_q holds the number of completed EXEC cycles. The watchdog therefore
  // fires in the cycle that would make the count reach TIMEOUT_CYCLES.
  // A simultaneous alu_ready_i takes priority over the abort.
  assign timeout = (state_q == EXEC) && is_div && !alu_ready_i &&
                   (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1));

  always_comb begin
    cnt_d = cnt_q;
    if (accept) begin
      cnt_d = '0;
    end else if ((state_q == EXEC) && is_div) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge core_clk or posedge rst) begin
    if (rst) cnt_q <= '0;
    else     cnt_q <= cnt_d;
  end
`else
  logic unused_timeout_cfg;
  assign unused_timeout_cfg = (TIMEOUT_CYCLES > 0);
  assign timeout            = 1'b0;
`endif

  always_comb begin
    state_d = state_q;
    op_d    = op_q;
    a_d     = a_q;
    b_d     = b_q;
    res_d   = res_q;
    cmp_d   = cmp_q;
    err_d   = err_q;

    case (state_q)
      IDLE: begin
        if (accept) state_d = EXEC;
      end
      EXEC: begin
        if (!is_div || alu_ready_i) begin
          res_d   = alu_result_i;
          cmp_d   = alu_comparison_result_i;
          err_d   = 1'b0;
          state_d = HOLD;
        end else if (timeout) begin
          res_d   = 32'hFFFF_FFFF;
          cmp_d   = 1'b0;
          err_d   = 1'b1;
          state_d = HOLD;
        end
      end
      HOLD: begin
        if (wb_ready_i) state_d = id_valid_i ? EXEC : IDLE;
      end
      default: state_d = IDLE;
    endcase

    // The operator and operands are loaded only on an ID handshake.
    // Otherwise they hold their values.
    if (accept) begin
      op_d = id_operator_i;
      a_d  = id_operand_a_i;
      b_d  = id_operand_b_i;
    end

    // The status outputs are registered as decodes of the next state.
    en_d   = (state_d == EXEC);
    wbv_d  = (state_d == HOLD);
    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge core_clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      op_q    <= '0;
      a_q     <= '0;
      b_q     <= '0;
      res_q   <= '0;
      cmp_q   <= 1'b0;
      err_q   <= 1'b0;
      en_q    <= 1'b0;
      wbv_q   <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      a_q     <= a_d;
      b_q     <= b_d;
      res_q   <= res_d;
      cmp_q   <= cmp_d;
      err_q   <= err_d;
      en_q    <= en_d;
      wbv_q   <= wbv_d;
      busy_q  <= busy_d;
    end
  end

  assign alu_enable_o    = en_q;
  assign alu_ex_ready_o  = en_q;
  assign alu_operator_o  = op_q;
  assign alu_operand_a_o = a_q;
  assign alu_operand_b_o = b_q;
  assign wb_valid_o      = wbv_q;
  assign wb_result_o     = res_q;
  assign wb_cmp_o        = cmp_q;
  assign wb_err_o        = err_q;
  assign busy_o          = busy_q;

endmodule

// File: tb/tb_alu_issue_ctrl.sv
`timescale 1ns / 1ps
// Directed testbench for alu_issue_ctrl. It uses a behavioural ALU model and
// checks writeback results against a scoreboard queue of expected values.
module tb_alu_issue_ctrl;

`ifdef ALU_ISSUE_TIMEOUT_EN
  localparam int TO      = 16;
  localparam int DIV_CYC = 10;
`else
  localparam int TO      = 64;
  localparam int DIV_CYC = 34;
`endif

  localparam logic [6:0] OP_ADD  = 7'd0;
  localparam logic [6:0] OP_SUB  = 7'd1;
  localparam logic [6:0] OP_SLT  = 7'd20;
  localparam logic [6:0] OP_DIV  = 7'd48;
  localparam logic [6:0] OP_DIVU = 7'd49;
  localparam logic [6:0] OP_REM  = 7'd50;
  localparam logic [6:0] OP_X52  = 7'd52;  // just outside the divide class

  logic        core_clk, rst;
  logic        id_valid_i, id_ready_o;
  logic [6:0]  id_operator_i;
  logic [31:0] id_operand_a_i, id_operand_b_i;
  logic        alu_enable_o, alu_ex_ready_o;
  logic [6:0]  alu_operator_o;
  logic [31:0] alu_operand_a_o, alu_operand_b_o;
  logic [31:0] alu_result_i;
  logic        alu_comparison_result_i, alu_ready_i;
  logic        wb_valid_o, wb_ready_i, wb_cmp_o, wb_err_o, busy_o;
  logic [31:0] wb_result_o;

  typedef struct packed {
    logic [31:0] res;
    logic        cmp;
    logic        err;
  } exp_t;

  exp_t sb[$];
  int   n_assert = 0;
  int   n_fail   = 0;
  logic ok;

  alu_issue_ctrl #(.OPCODE_W(7), .TIMEOUT_CYCLES(TO)) dut (
    .core_clk(core_clk), .rst(rst),
    .id_valid_i(id_valid_i), .id_ready_o(id_ready_o),
    .id_operator_i(id_operator_i),
    .id_operand_a_i(id_operand_a_i), .id_operand_b_i(id_operand_b_i),
    .alu_enable_o(alu_enable_o), .alu_operator_o(alu_operator_o),
    .alu_operand_a_o(alu_operand_a_o), .alu_operand_b_o(alu_operand_b_o),
    .alu_ex_ready_o(alu_ex_ready_o),
    .alu_result_i(alu_result_i),
    .alu_comparison_result_i(alu_comparison_result_i),
    .alu_ready_i(alu_ready_i),
    .wb_valid_o(wb_valid_o), .wb_ready_i(wb_ready_i),
    .wb_result_o(wb_result_o), .wb_cmp_o(wb_cmp_o), .wb_err_o(wb_err_o),
    .busy_o(busy_o)
  );

  initial core_clk = 1'b0;
  always #5 core_clk = ~core_clk;

  // Behavioural ALU: combinational datapath; alu_ready_i is driven by the sequence.
  always_comb begin
    alu_result_i            = alu_operand_a_o ^ alu_operand_b_o;
    alu_comparison_result_i = 1'b0;
    case (alu_operator_o)
      OP_ADD: alu_result_i = alu_operand_a_o + alu_operand_b_o;
      OP_SUB: alu_result_i = alu_operand_a_o - alu_operand_b_o;
      OP_SLT: begin
        alu_comparison_result_i = $signed(alu_operand_a_o) < $signed(alu_operand_b_o);
        alu_result_i            = {31'd0, alu_comparison_result_i};
      end
      OP_DIV:  alu_result_i = (alu_operand_b_o == 0) ? 32'hFFFF_FFFF :
                              32'($signed(alu_operand_a_o) / $signed(alu_operand_b_o));
      OP_DIVU: alu_result_i = (alu_operand_b_o == 0) ? 32'hFFFF_FFFF :
                              alu_operand_a_o / alu_operand_b_o;
      OP_REM:  alu_result_i = (alu_operand_b_o == 0) ? alu_operand_a_o :
                              32'($signed(alu_operand_a_o) % $signed(alu_operand_b_o));
      default: ;
    endcase
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(negedge core_clk);
  endtask

  task automatic issue(input logic [6:0] op, input logic [31:0] a, input logic [31:0] b);
    id_valid_i     = 1'b1;
    id_operator_i  = op;
    id_operand_a_i = a;
    id_operand_b_i = b;
    #1;
  endtask

  // Pop the oldest expected result and compare it with the writeback outputs.
  task automatic check_wb(input string tag);
    exp_t e;
    if (sb.size() == 0) begin
      n_assert++;
      n_fail++;
      $error("FAIL %s: observed empty scoreboard expected an entry", tag);
    end else begin
      e = sb.pop_front();
      chk({tag, "_valid"}, {31'd0, wb_valid_o}, 32'd1);
      chk({tag, "_res"}, wb_result_o, e.res);
      chk({tag, "_cmp"}, {31'd0, wb_cmp_o}, {31'd0, e.cmp});
      chk({tag, "_err"}, {31'd0, wb_err_o}, {31'd0, e.err});
    end
  endtask

  task automatic wait_wb(input string tag, input int max_cyc);
    int k = 0;
    while (!wb_valid_o && k < max_cyc) begin
      step();
      k++;
    end
    check_wb(tag);
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "global timeout");
  end

  initial begin
    rst = 1'b0; id_valid_i = 1'b0; id_operator_i = '0;
    id_operand_a_i = '0; id_operand_b_i = '0;
    alu_ready_i = 1'b0; wb_ready_i = 1'b0;
    #1 rst = 1'b1;
    #1;
    // The reset values must appear before any clock edge.
    chk("rst_id_ready", {31'd0, id_ready_o}, 32'd1);
    chk("rst_alu_en", {31'd0, alu_enable_o}, 32'd0);
    chk("rst_ex_ready", {31'd0, alu_ex_ready_o}, 32'd0);
    chk("rst_busy", {31'd0, busy_o}, 32'd0);
    chk("rst_wb_valid", {31'd0, wb_valid_o}, 32'd0);
    chk("rst_wb_res", wb_result_o, 32'd0);
    chk("rst_opa", alu_operand_a_o, 32'd0);
    step(); step();
    rst = 1'b0;
    step();

    // ADD 5+7: enable in N+1, result in N+2, then IDLE.
    wb_ready_i = 1'b1;
    issue(OP_ADD, 32'd5, 32'd7);
    chk("add_id_ready", {31'd0, id_ready_o}, 32'd1);
    sb.push_back('{res: 32'd12, cmp: 1'b0, err: 1'b0});
    step(); id_valid_i = 1'b0;
    chk("add_en", {31'd0, alu_enable_o}, 32'd1);
    chk("add_ex_ready", {31'd0, alu_ex_ready_o}, 32'd1);
    chk("add_opa", alu_operand_a_o, 32'd5);
    chk("add_opb", alu_operand_b_o, 32'd7);
    chk("add_exec_id_ready", {31'd0, id_ready_o}, 32'd0);
    chk("add_exec_wbv", {31'd0, wb_valid_o}, 32'd0);
    step();
    check_wb("add");
    step();
    chk("add_idle_busy", {31'd0, busy_o}, 32'd0);
    chk("add_idle_wbv", {31'd0, wb_valid_o}, 32'd0);

    // Opcode just outside the divide class completes in one EXEC cycle.
    issue(OP_X52, 32'h0000_F0F0, 32'h0000_0FF0);
    sb.push_back('{res: 32'h0000_FF00, cmp: 1'b0, err: 1'b0});
    step(); id_valid_i = 1'b0;
    step();
    check_wb("op52");
    step();

    // DIVU 100/7 with alu_ready_i raised in EXEC cycle DIV_CYC.
    issue(OP_DIVU, 32'd100, 32'd7);
    sb.push_back('{res: 32'd14, cmp: 1'b0, err: 1'b0});
    step(); id_valid_i = 1'b0;
    ok = 1'b1;
    for (int i = 1; i <= DIV_CYC; i++) begin
      if (!alu_enable_o || wb_valid_o) ok = 1'b0;
      if (i == DIV_CYC) alu_ready_i = 1'b1;
      else step();
    end
    step(); alu_ready_i = 1'b0;
    chk("divu_en_held", {31'd0, ok}, 32'd1);
    check_wb("divu");
    step();

    // Backpressure: SLT -1 < 1 held for three cycles, then retired.
    wb_ready_i = 1'b0;
    issue(OP_SLT, 32'hFFFF_FFFF, 32'd1);
    sb.push_back('{res: 32'd1, cmp: 1'b1, err: 1'b0});
    step(); id_valid_i = 1'b0;
    step();
    for (int i = 0; i < 3; i++) begin
      chk($sformatf("bp%0d_wbv", i), {31'd0, wb_valid_o}, 32'd1);
      chk($sformatf("bp%0d_cmp", i), {31'd0, wb_cmp_o}, 32'd1);
      chk($sformatf("bp%0d_res", i), wb_result_o, 32'd1);
      chk($sformatf("bp%0d_id_ready", i), {31'd0, id_ready_o}, 32'd0);
      step();
    end
    wb_ready_i = 1'b1; #1;
    chk("bp_id_ready_follow", {31'd0, id_ready_o}, 32'd1);
    check_wb("slt");
    step();
    chk("bp_idle_busy", {31'd0, busy_o}, 32'd0);

    // Back-to-back: SUB 9-4 accepted in the same edge that retires ADD 1+2.
    wb_ready_i = 1'b0;
    issue(OP_ADD, 32'd1, 32'd2);
    sb.push_back('{res: 32'd3, cmp: 1'b0, err: 1'b0});
    step(); id_valid_i = 1'b0;
    step();
    wb_ready_i = 1'b1;
    issue(OP_SUB, 32'd9, 32'd4);
    chk("b2b_id_ready", {31'd0, id_ready_o}, 32'd1);
    check_wb("b2b_first");
    sb.push_back('{res: 32'd5, cmp: 1'b0, err: 1'b0});
    step(); id_valid_i = 1'b0;
    chk("b2b_en", {31'd0, alu_enable_o}, 32'd1);
    chk("b2b_opa", alu_operand_a_o, 32'd9);
    chk("b2b_op", {25'd0, alu_operator_o}, {25'd0, OP_SUB});
    chk("b2b_wbv_exec", {31'd0, wb_valid_o}, 32'd0);
    step();
    check_wb("b2b_sub");
    step();

    // Reset in EXEC cycle 10 of a REM: outputs clear immediately.
    issue(OP_REM, 32'd100, 32'd7);
    step(); id_valid_i = 1'b0;
    for (int i = 1; i < 10; i++) step();
    rst = 1'b1; #1;
    chk("rstdiv_id_ready", {31'd0, id_ready_o}, 32'd1);
    chk("rstdiv_en", {31'd0, alu_enable_o}, 32'd0);
    chk("rstdiv_busy", {31'd0, busy_o}, 32'd0);
    chk("rstdiv_wbv", {31'd0, wb_valid_o}, 32'd0);
    chk("rstdiv_opa", alu_operand_a_o, 32'd0);
    chk("rstdiv_op", {25'd0, alu_operator_o}, 32'd0);
    rst = 1'b0;
    step();
    issue(OP_ADD, 32'd3, 32'd4);
    sb.push_back('{res: 32'd7, cmp: 1'b0, err: 1'b0});
    step(); id_valid_i = 1'b0;
    wait_wb("post_rst_add", 4);
    step();

`ifdef ALU_ISSUE_TIMEOUT_EN
    // DIV with alu_ready_i stuck low: abort after TO EXEC cycles.
    issue(OP_DIV, 32'd50, 32'd5);
    sb.push_back('{res: 32'hFFFF_FFFF, cmp: 1'b0, err: 1'b1});
    step(); id_valid_i = 1'b0;
    ok = 1'b1;
    for (int i = 1; i <= TO; i++) begin
      if (!alu_enable_o || wb_valid_o) ok = 1'b0;
      step();
    end
    chk("to_en_held", {31'd0, ok}, 32'd1);
    chk("to_en_drop", {31'd0, alu_enable_o}, 32'd0);
    check_wb("div_timeout");
    step();

    // alu_ready_i in the final allowed cycle wins over the watchdog.
    issue(OP_DIV, 32'd50, 32'd5);
    sb.push_back('{res: 32'd10, cmp: 1'b0, err: 1'b0});
    step(); id_valid_i = 1'b0;
    for (int i = 1; i <= TO; i++) begin
      if (i == TO) alu_ready_i = 1'b1;
      else step();
    end
    step(); alu_ready_i = 1'b0;
    check_wb("div_to_edge");
    step();
`else
    // Without the watchdog, a divide waits for alu_ready_i indefinitely.
    issue(OP_DIV, 32'd50, 32'd5);
    sb.push_back('{res: 32'd10, cmp: 1'b0, err: 1'b0});
    step(); id_valid_i = 1'b0;
    ok = 1'b1;
    for (int i = 1; i <= 40; i++) begin
      if (!alu_enable_o || wb_valid_o) ok = 1'b0;
      if (i == 40) alu_ready_i = 1'b1;
      else step();
    end
    step(); alu_ready_i = 1'b0;
    chk("div_wait_en_held", {31'd0, ok}, 32'd1);
    check_wb("div_long");
    step();
`endif

    chk("sb_drained", sb.size(), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
